// File: rtl/sha_1_pad.sv
// SHA-1 message padder: packs a 32-bit word stream into padded 512-bit blocks for the sha_1 core.
// Optional sticky error reporting (err port) is compiled in with SHA1_PAD_ERR_EN.
module sha_1_pad #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic [511:0] Data,
    output logic [63:0]  Index,
    output logic         Enable,
    input  logic         core_ready,
    output logic         busy,
    output logic         done
`ifdef SHA1_PAD_ERR_EN
    ,
    output logic         err
`endif
);

    typedef enum logic [1:0] {FILL, PAD, SEND, WAIT} state_t;

    state_t             state_reg, state_next;
    logic [3:0]         wcnt_reg, wcnt_next;
    logic [LEN_W-1:0]   blen_reg, blen_next, blen_add;
    logic [63:0]        index_reg, index_next;
    logic               mark_reg, mark_next;   // 0x80000000 word still owed
    logic               cont_reg, cont_next;   // length field goes in the following block
    logic               last_reg, last_next;   // current block carries the length
    logic               busy_reg, busy_next;
    logic               wr_en;
    logic [31:0]        wr_data;
    logic [31:0]        buf_reg [16];
    logic [31:0]        fill_word;
    logic [2:0]         bytes_eff;
    logic               short_last;
    logic               accept;
    logic               err_hit;
    logic [63:0]        blen64;

    assign bytes_eff  = (!in_last || in_bytes >= 3'd4) ? 3'd4 : in_bytes;
    assign short_last = in_last && (bytes_eff != 3'd4);
    assign accept     = in_valid && in_ready;

    // Keep the valid leading bytes, place the 0x80 marker right after them, zero the rest.
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign fill_word[31-8*gi -: 8] = (3'(gi) < bytes_eff)  ? in_data[31-8*gi -: 8] :
                                         (3'(gi) == bytes_eff) ? 8'h80 : 8'h00;
    end

    always_comb begin
        blen64 = '0;
        blen64[LEN_W-1:0] = blen_reg;
    end

`ifdef SHA1_PAD_ERR_EN
    logic             err_reg;
    logic [LEN_W:0]   blen_sum;

    assign blen_sum = {1'b0, blen_reg} + (LEN_W+1)'({bytes_eff, 3'b000});
    assign blen_add = blen_sum[LEN_W-1:0];
    assign err_hit  = accept && ((in_last && in_bytes > 3'd4) || blen_sum[LEN_W]);
    assign in_ready = (state_reg == FILL) && !err_reg;
    assign err      = err_reg;

    always_ff @(posedge clk) begin
        if (rst)
            err_reg <= 1'b0;
        else if (err_hit)
            err_reg <= 1'b1;
    end
`else
    assign blen_add = blen_reg + LEN_W'({bytes_eff, 3'b000});
    assign err_hit  = 1'b0;
    assign in_ready = (state_reg == FILL);
`endif

    assign Enable = (state_reg == SEND);
    assign done   = (state_reg == WAIT) && core_ready && last_reg;
    assign busy   = busy_reg;
    assign Index  = index_reg;

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        blen_next  = blen_reg;
        index_next = index_reg;
        mark_next  = mark_reg;
        cont_next  = cont_reg;
        last_next  = last_reg;
        busy_next  = busy_reg;
        wr_en      = 1'b0;
        wr_data    = '0;
        case (state_reg)
            FILL: begin
                if (accept && !err_hit) begin
                    wr_en     = 1'b1;
                    wr_data   = fill_word;
                    wcnt_next = wcnt_reg + 4'd1;
                    blen_next = blen_add;
                    busy_next = 1'b1;
                    if (in_last) begin
                        mark_next = !short_last;
                        if (wcnt_reg == 4'd15) begin
                            state_next = SEND;
                            cont_next  = 1'b1;
                        end else begin
                            state_next = PAD;
                            cont_next  = short_last && (wcnt_reg == 4'd14);
                        end
                    end else if (wcnt_reg == 4'd15) begin
                        state_next = SEND;
                    end
                end
            end
            PAD: begin
                wr_en     = 1'b1;
                wcnt_next = wcnt_reg + 4'd1;
                if (mark_reg) begin
                    wr_data   = 32'h8000_0000;
                    mark_next = 1'b0;
                    if (wcnt_reg >= 4'd14)
                        cont_next = 1'b1;
                end else if (!cont_reg && wcnt_reg == 4'd14) begin
                    wr_data = blen64[63:32];
                end else if (!cont_reg && wcnt_reg == 4'd15) begin
                    wr_data   = blen64[31:0];
                    last_next = 1'b1;
                end
                if (wcnt_reg == 4'd15)
                    state_next = SEND;
            end
            SEND: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (core_ready) begin
                    wcnt_next = '0;
                    if (last_reg) begin
                        index_next = '0;
                        blen_next  = '0;
                        last_next  = 1'b0;
                        busy_next  = 1'b0;
                        state_next = FILL;
                    end else begin
                        index_next = index_reg + 64'd1;
                        if (cont_reg) begin
                            cont_next  = 1'b0;
                            state_next = PAD;
                        end else begin
                            state_next = FILL;
                        end
                    end
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FILL;
            wcnt_reg  <= '0;
            blen_reg  <= '0;
            index_reg <= '0;
            mark_reg  <= 1'b0;
            cont_reg  <= 1'b0;
            last_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
            blen_reg  <= blen_next;
            index_reg <= index_next;
            mark_reg  <= mark_next;
            cont_reg  <= cont_next;
            last_reg  <= last_next;
            busy_reg  <= busy_next;
        end
    end

    // Block buffer: word gi of the block is presented at Data[32*gi +: 32].
    for (genvar gi = 0; gi < 16; gi++) begin : g_word
        always_ff @(posedge clk) begin
            if (rst)
                buf_reg[gi] <= '0;
            else if (wr_en && wcnt_reg == 4'(gi))
                buf_reg[gi] <= wr_data;
        end
        assign Data[32*gi +: 32] = buf_reg[gi];
    end

endmodule

// File: tb/tb_sha_1_pad.sv
// Directed bench for sha_1_pad: drives messages, models the core's Ready handshake, checks block contents.
module tb_sha_1_pad;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic [511:0] Data;
    logic [63:0]  Index;
    logic         Enable;
    logic         core_ready;
    logic         busy;
    logic         done;
`ifdef SHA1_PAD_ERR_EN
    logic         err;
`endif

    always #5 clk = ~clk;

    sha_1_pad #(.LEN_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_bytes   (in_bytes),
        .Data       (Data),
        .Index      (Index),
        .Enable     (Enable),
        .core_ready (core_ready),
        .busy       (busy),
        .done       (done)
`ifdef SHA1_PAD_ERR_EN
        ,
        .err        (err)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int en_cyc = 0;
    int blk_cnt = 0;
    int done_cnt = 0;
    bit core_auto = 1'b1;
    logic [511:0] blk_data [8];
    logic [63:0]  blk_idx [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int b, input int i);
        return blk_data[b][32*i +: 32];
    endfunction

    function automatic logic [31:0] orw(input int b, input int lo, input int hi);
        logic [31:0] r = '0;
        for (int i = lo; i <= hi; i++) r |= blk_data[b][32*i +: 32];
        return r;
    endfunction

    // Core model: capture each block on Enable, answer with a Ready pulse a few cycles later.
    initial begin
        core_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (Enable === 1'b1) begin
                if (blk_cnt < 8) begin
                    blk_data[blk_cnt] = Data;
                    blk_idx[blk_cnt]  = Index;
                end
                blk_cnt++;
                en_cyc = cyc;
                @(negedge clk);
                chk("enable_one_cycle", 64'(Enable), 64'd0);
                chk("wait_in_ready", 64'(in_ready), 64'd0);
                if (core_auto) begin
                    repeat (2) @(negedge clk);
                    core_ready = 1'b1;
                    #1;
                    if (done === 1'b1) done_cnt++;
                    @(negedge clk);
                    core_ready = 1'b0;
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        while (in_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n);
        int t = 0;
        while (done_cnt < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
        chk(tag, 64'(done_cnt), 64'(n));
    endtask

    task automatic clear();
        blk_cnt  = 0;
        done_cnt = 0;
    endtask

    initial begin
        int lat;
        int t;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        in_bytes = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_enable", 64'(Enable), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_index", Index, 64'd0);
        chk("rst_data", 64'(|Data), 64'd0);
        rst = 1'b0;

        // "abc"
        clear();
        send_word(32'h6162_6300, 1'b1, 3'd3);
        lat = acc_cyc;
        @(negedge clk);
        chk("abc_busy", 64'(busy), 64'd1);
        wait_done("abc_done", 1);
        chk("abc_blocks", 64'(blk_cnt), 64'd1);
        chk("abc_w0", 64'(wd(0, 0)), 64'h6162_6380);
        chk("abc_zero", 64'(orw(0, 1, 14)), 64'd0);
        chk("abc_w15", 64'(wd(0, 15)), 64'h18);
        chk("abc_idx", blk_idx[0], 64'd0);
        chk("abc_latency", 64'(en_cyc - lat), 64'd15);
        chk("abc_busy_end", 64'(busy), 64'd0);
        $display("msg abc: blocks=%0d done=%0d", blk_cnt, done_cnt);

        // empty message
        clear();
        send_word(32'hDEAD_BEEF, 1'b1, 3'd0);
        wait_done("empty_done", 1);
        chk("empty_blocks", 64'(blk_cnt), 64'd1);
        chk("empty_w0", 64'(wd(0, 0)), 64'h8000_0000);
        chk("empty_zero", 64'(orw(0, 1, 15)), 64'd0);
        chk("empty_idx", blk_idx[0], 64'd0);
        $display("msg empty: blocks=%0d done=%0d", blk_cnt, done_cnt);

        // 14 full words, marker lands at slot 14 -> length spills into a second block
        clear();
        for (int k = 0; k < 14; k++)
            send_word(32'h0100_0000 + 32'(k), (k == 13), 3'd4);
        wait_done("w14_done", 1);
        chk("w14_blocks", 64'(blk_cnt), 64'd2);
        chk("w14_b0_w0", 64'(wd(0, 0)), 64'h0100_0000);
        chk("w14_b0_w13", 64'(wd(0, 13)), 64'h0100_000D);
        chk("w14_b0_w14", 64'(wd(0, 14)), 64'h8000_0000);
        chk("w14_b0_w15", 64'(wd(0, 15)), 64'd0);
        chk("w14_b0_idx", blk_idx[0], 64'd0);
        chk("w14_b1_zero", 64'(orw(1, 0, 14)), 64'd0);
        chk("w14_b1_w15", 64'(wd(1, 15)), 64'h1C0);
        chk("w14_b1_idx", blk_idx[1], 64'd1);
        $display("msg 14w: blocks=%0d done=%0d", blk_cnt, done_cnt);

        // 16 full words + one byte
        clear();
        for (int k = 0; k < 16; k++)
            send_word(32'h1000_0000 + 32'(k), 1'b0, 3'd4);
        send_word(32'hAB12_3456, 1'b1, 3'd1);
        lat = acc_cyc;
        wait_done("w17_done", 1);
        chk("w17_blocks", 64'(blk_cnt), 64'd2);
        chk("w17_b0_w15", 64'(wd(0, 15)), 64'h1000_000F);
        chk("w17_b0_idx", blk_idx[0], 64'd0);
        chk("w17_b1_w0", 64'(wd(1, 0)), 64'hAB80_0000);
        chk("w17_b1_zero", 64'(orw(1, 1, 14)), 64'd0);
        chk("w17_b1_w15", 64'(wd(1, 15)), 64'h208);
        chk("w17_b1_idx", blk_idx[1], 64'd1);
        chk("w17_latency", 64'(en_cyc - lat), 64'd15);
        $display("msg 17w: blocks=%0d done=%0d", blk_cnt, done_cnt);

        // reset while waiting for the core, then a stale Ready
        clear();
        core_auto = 1'b0;
        send_word(32'h6162_6300, 1'b1, 3'd3);
        t = 0;
        while (blk_cnt < 1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("rstw_enable_seen", 64'(blk_cnt), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        core_ready = 1'b1;
        #1;
        chk("rstw_done", 64'(done), 64'd0);
        @(negedge clk);
        core_ready = 1'b0;
        chk("rstw_enable", 64'(Enable), 64'd0);
        chk("rstw_in_ready", 64'(in_ready), 64'd1);
        chk("rstw_index", Index, 64'd0);
        chk("rstw_busy", 64'(busy), 64'd0);
        core_auto = 1'b1;
        clear();
        send_word(32'h6162_6300, 1'b1, 3'd3);
        wait_done("rstw2_done", 1);
        chk("rstw2_blocks", 64'(blk_cnt), 64'd1);
        chk("rstw2_w0", 64'(wd(0, 0)), 64'h6162_6380);
        chk("rstw2_w15", 64'(wd(0, 15)), 64'h18);
        chk("rstw2_idx", blk_idx[0], 64'd0);
        $display("msg rst-in-wait: blocks=%0d done=%0d", blk_cnt, done_cnt);

`ifdef SHA1_PAD_ERR_EN
        // oversize byte count is an error: no block is ever started
        clear();
        send_word(32'h1122_3344, 1'b1, 3'd5);
        @(negedge clk);
        chk("err_flag", 64'(err), 64'd1);
        chk("err_in_ready", 64'(in_ready), 64'd0);
        repeat (40) @(negedge clk);
        chk("err_blocks", 64'(blk_cnt), 64'd0);
        chk("err_sticky", 64'(err), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("err_cleared", 64'(err), 64'd0);
        $display("msg err bytes=5: blocks=%0d", blk_cnt);
`else
        // oversize byte count treated as a full word
        clear();
        send_word(32'h1122_3344, 1'b1, 3'd5);
        wait_done("b5_done", 1);
        chk("b5_blocks", 64'(blk_cnt), 64'd1);
        chk("b5_w0", 64'(wd(0, 0)), 64'h1122_3344);
        chk("b5_w1", 64'(wd(0, 1)), 64'h8000_0000);
        chk("b5_zero", 64'(orw(0, 2, 14)), 64'd0);
        chk("b5_w15", 64'(wd(0, 15)), 64'h20);
        $display("msg bytes=5: blocks=%0d done=%0d", blk_cnt, done_cnt);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
